tick_rate_arbiter: RTL and testbench

//  Shares one programmable clock-divider counter between NREQ requesters, each

---
 rtl/tick_rate_arbiter_pkg.sv | 12 +
 rtl/tick_rate_arbiter_rr_arbiter.sv | 33 +++
 rtl/tick_rate_arbiter.sv | 148 ++++++++++++++
 tb/tb_tick_rate_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_rate_arbiter_pkg.sv
// Shared definitions for the tick-rate arbiter: FSM encoding and the reset rate.
// DEFAULT_HALF_1HZ is the half-period that gives 1 Hz from a 100 MHz clock.
package tick_rate_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_HALF_1HZ = 32'd50_000_000;

endpackage

// File: rtl/tick_rate_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after ptr_i wins.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    valid_o
);

    localparam int IDW = $clog2(NREQ);

    // Walk the requests starting at the pointer and stop at the first hit.
    always_comb begin
        int cand;
        cand    = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_i) + k) % NREQ;
            if (!valid_o && req_i[cand[IDW-1:0]]) begin
                valid_o                = 1'b1;
                idx_o                  = cand[IDW-1:0];
                gnt_o[cand[IDW-1:0]]   = 1'b1;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/tick_rate_arbiter.sv
// Programmable clock divider shared by NREQ rate requesters; a rate change is
// captured by round-robin arbitration and committed only on a counter boundary.
module tick_rate_arbiter
    import tick_rate_arbiter_pkg::*;
#(
    parameter int          NREQ         = 3,
    parameter int          CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_1HZ
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*CNT_W-1:0]   half_period,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] active_id,
    output logic                    busy,
    output logic                    clkout,
    output logic                    tick
);

    localparam int IDW = $clog2(NREQ);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cur_half_q, cur_half_d;
    logic [CNT_W-1:0]   nxt_half_q, nxt_half_d;
    logic [IDW-1:0]     nxt_id_q, nxt_id_d;
    logic [NREQ-1:0]    nxt_oh_q, nxt_oh_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     active_q, active_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               clkout_q, clkout_d;
    logic               tick_q, tick_d;

    logic [CNT_W-1:0]   eff_half_s;
    logic               boundary_s;
    logic [NREQ-1:0]    arb_gnt_s;
    logic [IDW-1:0]     arb_idx_s;
    logic               arb_valid_s;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt_s),
        .idx_o   (arb_idx_s),
        .valid_o (arb_valid_s)
    );

    // A programmed half-period of 0 behaves as 1 so the counter always has a boundary.
    assign eff_half_s = (cur_half_q == '0) ? CNT_W'(1) : cur_half_q;
    assign boundary_s = en && (cnt_q == eff_half_s - CNT_W'(1));

    // Divider, capture and commit next-state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_half_d = cur_half_q;
        nxt_half_d = nxt_half_q;
        nxt_id_d   = nxt_id_q;
        nxt_oh_d   = nxt_oh_q;
        ptr_d      = ptr_q;
        active_d   = active_q;
        gnt_d      = '0;
        busy_d     = busy_q;
        clkout_d   = clkout_q;
        tick_d     = boundary_s & ~clkout_q;

        if (boundary_s) begin
            cnt_d    = '0;
            clkout_d = ~clkout_q;
        end else if (en) begin
            cnt_d    = cnt_q + CNT_W'(1);
        end else begin
            cnt_d    = cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    nxt_half_d = half_period[int'(arb_idx_s)*CNT_W +: CNT_W];
                    nxt_id_d   = arb_idx_s;
                    nxt_oh_d   = arb_gnt_s;
                    busy_d     = 1'b1;
                    state_d    = ST_PEND;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_PEND: begin
                // Committing with the toggle gives the new rate a full first phase.
                if (boundary_s || !en) begin
                    cur_half_d = nxt_half_q;
                    active_d   = nxt_id_q;
                    cnt_d      = '0;
                    gnt_d      = nxt_oh_q;
                    busy_d     = 1'b0;
                    ptr_d      = (nxt_id_q == IDW'(NREQ-1)) ? '0 : nxt_id_q + IDW'(1);
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_PEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_half_q <= CNT_W'(DEFAULT_HALF);
            nxt_half_q <= '0;
            nxt_id_q   <= '0;
            nxt_oh_q   <= '0;
            ptr_q      <= '0;
            active_q   <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            clkout_q   <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_half_q <= cur_half_d;
            nxt_half_q <= nxt_half_d;
            nxt_id_q   <= nxt_id_d;
            nxt_oh_q   <= nxt_oh_d;
            ptr_q      <= ptr_d;
            active_q   <= active_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            clkout_q   <= clkout_d;
            tick_q     <= tick_d;
        end
    end

    assign gnt       = gnt_q;
    assign active_id = active_q;
    assign busy      = busy_q;
    assign clkout    = clkout_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_tick_rate_arbiter.sv
// Directed plus randomized bench for tick_rate_arbiter against a cycle-level
// reference model that keeps the pending rate change as a one-entry queue.
module tb_tick_rate_arbiter;

    localparam int NREQ  = 3;
    localparam int CNT_W = 8;
    localparam int DEF   = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] half_period;
    logic [NREQ-1:0]       gnt;
    logic [1:0]            active_id;
    logic                  busy;
    logic                  clkout;
    logic                  tick;

    tick_rate_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W), .DEFAULT_HALF(DEF)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .half_period(half_period),
        .gnt(gnt), .active_id(active_id), .busy(busy), .clkout(clkout), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct { int half; int id; } chg_t;

    int   vectors     = 0;
    int   miscompares = 0;
    chg_t pend_q[$];
    int   m_cnt, m_half, m_ptr, m_active;
    bit   m_clk, m_tick;
    bit [NREQ-1:0] m_gnt;
    bit   autodrop = 1'b1;
    int   gnt_seen[$];

    function automatic int eff(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_half = DEF; m_ptr = 0; m_active = 0;
        m_clk = 1'b0; m_tick = 1'b0; m_gnt = '0;
        pend_q.delete();
    endtask

    // One clock edge of the reference behaviour, from the current inputs.
    task automatic model_edge();
        bit bnd;
        bnd    = en && (m_cnt == eff(m_half) - 1);
        m_tick = bnd && !m_clk;
        m_gnt  = '0;
        if (en) begin
            if (bnd) begin m_clk = !m_clk; m_cnt = 0; end
            else m_cnt++;
        end
        if (pend_q.size() != 0) begin
            if (bnd || !en) begin
                chg_t c;
                c = pend_q.pop_front();
                m_half = c.half; m_active = c.id; m_cnt = 0;
                m_gnt[c.id] = 1'b1;
                m_ptr = (c.id + 1) % NREQ;
            end
        end else if (req != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                int w;
                w = (m_ptr + k) % NREQ;
                if (req[w]) begin
                    pend_q.push_back('{int'(half_period[w*CNT_W +: CNT_W]), w});
                    break;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("clkout",    32'(clkout),    32'(m_clk));
        chk("tick",      32'(tick),      32'(m_tick));
        chk("gnt",       32'(gnt),       32'(m_gnt));
        chk("busy",      32'(busy),      32'(pend_q.size() != 0));
        chk("active_id", 32'(active_id), 32'(m_active));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_seen.push_back(i);
        if (autodrop) req = req & ~gnt;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_half(input int idx, input int val);
        half_period[idx*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    // Asynchronous reset asserted away from the clock edge, checked immediately.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_clkout", 32'(clkout),    32'd0);
        chk("rst_tick",   32'(tick),      32'd0);
        chk("rst_gnt",    32'(gnt),       32'd0);
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_active", 32'(active_id), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; req = '0; half_period = '0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;

        // 1: default rate, no requests
        en = 1'b1;
        run(20);

        // 2: req[1] with half=2 mid-period
        run(2);
        set_half(1, 2);
        req = 3'b010;
        step();
        chk("t2_busy", 32'(busy), 32'd1);
        run(16);

        // 3: all three request at once from pointer 0
        do_reset();
        set_half(0, 3); set_half(1, 1); set_half(2, 2);
        gnt_seen.delete();
        req = 3'b111;
        run(40);
        chk("t3_ngnt", 32'(gnt_seen.size()), 32'd3);
        for (int i = 0; i < 3 && i < gnt_seen.size(); i++)
            chk("t3_order", 32'(gnt_seen[i]), 32'(i));

        // 4: capture req[2], then drop it and freeze the divider
        set_half(2, 6);
        req = 3'b100;
        step();
        req = 3'b000;
        en = 1'b0;
        set_half(2, 1);
        step();
        chk("t4_gnt", 32'(gnt), 32'b100);
        run(4);
        en = 1'b1;
        run(20);

        // 5: half-period 0 behaves as 1
        set_half(0, 0);
        req = 3'b001;
        run(14);

        // 6: reset while a change is pending
        set_half(1, 3);
        req = 3'b010;
        step();
        chk("t6_busy", 32'(busy), 32'd1);
        req = 3'b000;
        do_reset();
        gnt_seen.delete();
        run(20);
        chk("t6_nognt", 32'(gnt_seen.size()), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 4) == 0) begin
                int r;
                r = $urandom_range(0, NREQ-1);
                if (!req[r]) set_half(r, $urandom_range(0, 5));
                req[r] = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) req = '0;
            if ($urandom_range(0, 9) == 0) set_half($urandom_range(0, NREQ-1), $urandom_range(0, 5));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
